video_preproc: RTL and testbench

VIDEO_PREPROC -- requirements
Module: video_preproc

---
 rtl/video_pkg.sv | 13 +
 rtl/rgb2luma.sv | 28 ++
 rtl/video_preproc.sv | 146 ++++++++++++++
 tb/tb_video_preproc.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: luma coefficients, rounding constant and geometry FSM encoding
// shared by video_preproc and rgb2luma.
package video_pkg;
    localparam logic [15:0] Y_COEF_R = 16'd77;
    localparam logic [15:0] Y_COEF_G = 16'd150;
    localparam logic [15:0] Y_COEF_B = 16'd29;
    localparam logic [15:0] Y_ROUND  = 16'd128;
    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } geom_state_t;
endpackage

// File: rtl/rgb2luma.sv
// rgb2luma: 3-stage luma Y = (77R + 150G + 29B + 128) >> 8, rgb packed {blue, green, red}.
module rgb2luma
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    output logic [7:0]  y
);
    logic [15:0] pr, pg, pb, sum;

    // 16 bits suffice: the coefficients sum to 256, so the worst case is 255*256 + 128
    always_ff @(posedge clk) begin
        if (rst) begin
            pr  <= '0;
            pg  <= '0;
            pb  <= '0;
            sum <= '0;
            y   <= '0;
        end else begin
            pr  <= Y_COEF_R * {8'd0, rgb[7:0]};
            pg  <= Y_COEF_G * {8'd0, rgb[15:8]};
            pb  <= Y_COEF_B * {8'd0, rgb[23:16]};
            sum <= pr + pg + pb + Y_ROUND;
            y   <= 8'(sum >> 8);
        end
    end
endmodule

// File: rtl/video_preproc.sv
// video_preproc: 3-cycle pixel path (grayscale when VIDEO_PREPROC_GRAY_EN is defined, else
// pass-through) plus active-geometry measurement that locks after LOCK_FRAMES good frames.
module video_preproc
    import video_pkg::*;
#(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      rgb_in,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    output logic [23:0]      rgb_out,
    output logic             de_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [CNT_W-1:0] width_out,
    output logic [CNT_W-1:0] height_out,
    output logic             geom_valid
);
    localparam logic [7:0] LOCK_M = 8'(LOCK_FRAMES);

    logic [2:0]  de_d, hs_d, vs_d;
    logic [23:0] pix;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_d <= '0;
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            de_d <= {de_d[1:0], de};
            hs_d <= {hs_d[1:0], hsync};
            vs_d <= {vs_d[1:0], vsync};
        end
    end

`ifdef VIDEO_PREPROC_GRAY_EN
    logic [7:0] y;
    rgb2luma u_luma (.clk(clk), .rst(rst), .rgb(rgb_in), .y(y));
    assign pix = {y, y, y};
`else
    logic [23:0] p1, p2, p3;
    always_ff @(posedge clk) begin
        if (rst) begin
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
        end else begin
            p1 <= rgb_in;
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign pix = p3;
`endif

    assign rgb_out   = de_d[2] ? pix : '0;
    assign de_out    = de_d[2];
    assign hsync_out = hs_d[2];
    assign vsync_out = vs_d[2];

    logic             de_q, vs_q, vs_rise, de_fall;
    logic [CNT_W-1:0] pix_cnt, line_cnt, ref_w, prev_w, prev_h, fw, fh;
    logic             have_line, bad, fbad, same, load, drop;
    logic [7:0]       match, match_nxt;
    geom_state_t      state, state_nxt;

    assign vs_rise = vsync & ~vs_q;
    assign de_fall = de_q & ~de;

    // Frame view with the current line already closed, so a coincident vs_rise includes it
    assign fh   = (de_fall && line_cnt != '1) ? line_cnt + 1'b1 : line_cnt;
    assign fw   = (de_fall && !have_line) ? pix_cnt : ref_w;
    assign fbad = bad | (de_fall & ((pix_cnt == '1) | (fh == '1) | (have_line & (pix_cnt != ref_w))));
    assign same = (fw == prev_w) && (fh == prev_h);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        match_nxt = match;
        load      = 1'b0;
        drop      = 1'b0;
        if (vs_rise) begin
            unique case (state)
                WAIT_VS: state_nxt = MEASURE;
                MEASURE: begin
                    match_nxt = fbad ? 8'd0 : !same ? 8'd1 : (match < LOCK_M) ? match + 8'd1 : match;
                    load      = match_nxt >= LOCK_M;
                    state_nxt = load ? LOCKED : MEASURE;
                end
                LOCKED: begin
                    drop      = fbad | (fw != width_out) | (fh != height_out);
                    match_nxt = drop ? 8'd0 : match;
                    state_nxt = drop ? MEASURE : LOCKED;
                end
                default: state_nxt = WAIT_VS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q       <= 1'b0;
            vs_q       <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            ref_w      <= '0;
            prev_w     <= '0;
            prev_h     <= '0;
            have_line  <= 1'b0;
            bad        <= 1'b0;
            match      <= '0;
            width_out  <= '0;
            height_out <= '0;
            geom_valid <= 1'b0;
        end else begin
            de_q      <= de;
            vs_q      <= vsync;
            pix_cnt   <= !de ? '0 : (pix_cnt == '1) ? pix_cnt : pix_cnt + 1'b1;
            line_cnt  <= vs_rise ? '0 : fh;
            ref_w     <= vs_rise ? '0 : fw;
            have_line <= ~vs_rise & (have_line | de_fall);
            bad       <= ~vs_rise & fbad;
            match     <= match_nxt;
            if (vs_rise && state != WAIT_VS) begin
                prev_w <= fw;
                prev_h <= fh;
            end
            if (load) begin
                width_out  <= fw;
                height_out <= fh;
            end
            geom_valid <= load | (geom_valid & ~drop);
        end
    end
endmodule

// File: tb/tb_video_preproc.sv
// tb_video_preproc: directed checks of the pixel pipeline, geometry lock/unlock,
// counter saturation and mid-frame reset, using a reduced 40x12 frame.
module tb_video_preproc;
    localparam int W = 40;
    localparam int H = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] rgb_in = '0;
    logic        de = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [23:0] rgb_out;
    logic        de_out, hsync_out, vsync_out, geom_valid;
    logic [11:0] width_out, height_out;
    int          vectors = 0;
    int          miscompares = 0;

    logic [23:0] vp [8] = '{24'hffffff, 24'h000000, 24'h0000ff, 24'h123456,
                            24'habcdef, 24'h5a5a5a, 24'h000000, 24'h000000};
`ifdef VIDEO_PREPROC_GRAY_EN
    logic [23:0] ep [6] = '{24'hffffff, 24'h000000, 24'h4d4d4d, 24'h3a3a3a,
                            24'h000000, 24'h5a5a5a};
`else
    logic [23:0] ep [6] = '{24'hffffff, 24'h000000, 24'h0000ff, 24'h123456,
                            24'h000000, 24'h5a5a5a};
`endif
    logic [7:0] vd = 8'b0010_1111;
    logic [7:0] vh = 8'b0001_1010;
    logic [7:0] vv = 8'b0000_1100;

    video_preproc dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .de(de), .hsync(hsync), .vsync(vsync),
        .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .width_out(width_out), .height_out(height_out), .geom_valid(geom_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line(input int w);
        de = 1'b1;
        rgb_in = 24'h808080;
        repeat (w) tick();
        de = 1'b0;
        rgb_in = '0;
        hsync = 1'b1;
        repeat (2) tick();
        hsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic frame_vs(input string tag, input int short_idx, input logic ev, input int ew, input int eh);
        for (int i = 0; i < H; i++) line(i == short_idx ? W - 1 : W);
        vsync = 1'b1;
        tick();
        check({tag, " geom_valid"}, 32'(geom_valid), 32'(ev));
        check({tag, " width_out"}, 32'(width_out), 32'(ew));
        check({tag, " height_out"}, 32'(height_out), 32'(eh));
        tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rgb_out"}, 32'(rgb_out), 32'd0);
        check({tag, " de_out"}, 32'(de_out), 32'd0);
        check({tag, " hsync_out"}, 32'(hsync_out), 32'd0);
        check({tag, " vsync_out"}, 32'(vsync_out), 32'd0);
        check({tag, " width_out"}, 32'(width_out), 32'd0);
        check({tag, " height_out"}, 32'(height_out), 32'd0);
        check({tag, " geom_valid"}, 32'(geom_valid), 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            rgb_in = vp[i];
            de = vd[i];
            hsync = vh[i];
            vsync = vv[i];
            tick();
            if (i >= 2) begin
                check($sformatf("pix%0d rgb_out", i - 2), 32'(rgb_out), 32'(ep[i - 2]));
                check($sformatf("pix%0d de_out", i - 2), 32'(de_out), 32'(vd[i - 2]));
                check($sformatf("pix%0d hsync_out", i - 2), 32'(hsync_out), 32'(vh[i - 2]));
                check($sformatf("pix%0d vsync_out", i - 2), 32'(vsync_out), 32'(vv[i - 2]));
            end
        end

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        frame_vs("discard", -1, 1'b0, 0, 0);
        frame_vs("match1", -1, 1'b0, 0, 0);
        frame_vs("lock", -1, 1'b1, W, H);
        frame_vs("short_line", 5, 1'b0, W, H);
        frame_vs("relock1", -1, 1'b0, W, H);
        frame_vs("relock2", -1, 1'b1, W, H);

        de = 1'b1;
        rgb_in = 24'h808080;
        repeat (5000) tick();
        check("sat pix_cnt", 32'(dut.pix_cnt), 32'd4095);
        de = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        tick();
        check("sat geom_valid", 32'(geom_valid), 32'd0);
        check("sat width_out", 32'(width_out), 32'(W));
        tick();
        vsync = 1'b0;
        repeat (3) tick();
        frame_vs("post_sat1", -1, 1'b0, W, H);
        frame_vs("post_sat2", -1, 1'b1, W, H);

        de = 1'b1;
        rgb_in = 24'h808080;
        repeat (10) tick();
        check("pre_rst de_out", 32'(de_out), 32'd1);
        rst = 1'b1;
        tick();
        check_zero("mid_rst");
        rst = 1'b0;
        repeat (W - 11) tick();
        de = 1'b0;
        repeat (4) tick();
        frame_vs("rst_discard", -1, 1'b0, 0, 0);
        frame_vs("rst_match1", -1, 1'b0, 0, 0);
        frame_vs("rst_lock", -1, 1'b1, W, H);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
